// File: rtl/lp_dma_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : lp_dma_unpack
//  Purpose  : LP20 DMA byte-fetch engine; reads 16-bit words and hands out
//             bytes in PDP-11 little-endian order. Optional parity check is
//             built when LPDMA_PARITY_EN is defined.
//  Revision : 1.0
// ============================================================================
module lp_dma_unpack #(
    parameter int AW  = 18,
    parameter int TMO = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lpINIT,
    input  logic          lpGO,
    input  logic [AW-1:0] lpBAR,
    input  logic          lpSETDONE,
    output logic          dmaREQ,
    output logic [AW-1:0] dmaADDR,
    input  logic          dmaACK,
    input  logic [15:0]   dmaDATA,
    input  logic [1:0]    dmaPAR,
    output logic [7:0]    byteDATA,
    output logic          byteVALID,
    input  logic          byteREADY,
    output logic          lpINCBCTR,
    output logic          lpINCBAR,
    output logic          lpBUSY,
    output logic          lpSETNXM,
    output logic          lpSETPAR
);

    localparam int              c_CW       = $clog2(TMO);
    localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'(TMO - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_BYTE  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [c_CW-1:0] r_cnt;
    logic [15:0]     r_word;
    logic            r_gap;
    logic            r_nxm;
    logic            r_par_err;
    logic            w_hs;
    logic            w_nxm;
    logic            w_par_set;
    logic            w_ack_bad;
    logic            w_hi_bad;

`ifdef LPDMA_PARITY_EN
    logic [1:0] r_par;

    // Odd parity: a good byte has ^byte ^ bit == 1.
    assign w_ack_bad = lpBAR[0] ? ~(^dmaDATA[15:8] ^ dmaPAR[1])
                                : ~(^dmaDATA[7:0]  ^ dmaPAR[0]);
    assign w_hi_bad  = ~(^r_word[15:8] ^ r_par[1]);

    always_ff @(posedge clk) begin
        if (rst || lpINIT) begin
            r_par <= 2'b00;
        end else if (r_state == c_FETCH && dmaACK) begin
            r_par <= dmaPAR;
        end
    end
`else
    logic w_unused_par;

    assign w_ack_bad    = 1'b0;
    assign w_hi_bad     = 1'b0;
    assign w_unused_par = ^dmaPAR;
`endif

    always_ff @(posedge clk) begin
        if (rst || lpINIT) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_word    <= 16'h0000;
            r_gap     <= 1'b0;
            r_nxm     <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (r_state == c_FETCH && w_next == c_FETCH) ? r_cnt + c_CW'(1) : '0;
            if (r_state == c_FETCH && dmaACK) begin
                r_word <= dmaDATA;
            end
            // One dead cycle after a low-byte handshake lets lpBAR advance.
            r_gap     <= w_hs && (w_next == c_BYTE);
            r_nxm     <= w_nxm;
            r_par_err <= w_par_set;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_nxm     = 1'b0;
        w_par_set = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (lpGO) begin
                    w_next = c_FETCH;
                end
            end
            c_FETCH: begin
                if (dmaACK) begin
                    if (w_ack_bad) begin
                        w_next    = c_IDLE;
                        w_par_set = 1'b1;
                    end else begin
                        w_next = c_BYTE;
                    end
                end else if (r_cnt == c_TMO_LAST) begin
                    w_next = c_IDLE;
                    w_nxm  = 1'b1;
                end
            end
            c_BYTE: begin
                if (w_hs) begin
                    if (lpSETDONE) begin
                        w_next = c_IDLE;
                    end else if (!lpBAR[0]) begin
                        if (w_hi_bad) begin
                            w_next    = c_IDLE;
                            w_par_set = 1'b1;
                        end
                    end else begin
                        w_next = c_FETCH;
                    end
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        dmaREQ    = (r_state == c_FETCH);
        dmaADDR   = dmaREQ ? {lpBAR[AW-1:1], 1'b0} : '0;
        byteVALID = (r_state == c_BYTE) && !r_gap;
        w_hs      = byteVALID && byteREADY;
        byteDATA  = byteVALID ? (lpBAR[0] ? r_word[15:8] : r_word[7:0]) : 8'h00;
        lpINCBCTR = w_hs;
        lpINCBAR  = w_hs;
        lpBUSY    = (r_state != c_IDLE);
    end

    assign lpSETNXM = r_nxm;
    assign lpSETPAR = r_par_err;

endmodule
`default_nettype wire

// File: tb/tb_lp_dma_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lp_dma_unpack
//  Purpose  : Self-checking bench for lp_dma_unpack with bus/memory and
//             byte-counter models; expected bytes come from a memory image.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_lp_dma_unpack;

    localparam int AW  = 18;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst, lpINIT, lpGO, lpSETDONE, dmaACK, byteREADY;
    logic [AW-1:0] lpBAR;
    logic [15:0]   dmaDATA;
    logic [1:0]    dmaPAR;
    logic          dmaREQ, byteVALID, lpINCBCTR, lpINCBAR, lpBUSY, lpSETNXM, lpSETPAR;
    logic [AW-1:0] dmaADDR;
    logic [7:0]    byteDATA;

    always #5 clk = ~clk;

    lp_dma_unpack #(.AW(AW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .lpINIT(lpINIT), .lpGO(lpGO), .lpBAR(lpBAR),
        .lpSETDONE(lpSETDONE), .dmaREQ(dmaREQ), .dmaADDR(dmaADDR),
        .dmaACK(dmaACK), .dmaDATA(dmaDATA), .dmaPAR(dmaPAR),
        .byteDATA(byteDATA), .byteVALID(byteVALID), .byteREADY(byteREADY),
        .lpINCBCTR(lpINCBCTR), .lpINCBAR(lpINCBAR), .lpBUSY(lpBUSY),
        .lpSETNXM(lpSETNXM), .lpSETPAR(lpSETPAR)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] mem [256];
    logic [7:0]  got [$];
    int          bc_rem, episodes, req_cycles, nxm_cnt, nxm_at, par_cnt;
    int          valid_cnt, pre_hs_valid, lat, wcnt, hold_left;
    bit          inc_pend, req_prev, prev_hs, prev_valid, seen_hs;
    bit          ack_en, force_ack, bad_lo, go_noise, go_req, rnd_ready;
    logic [7:0]  prev_data;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [AW-1:0] a);
        return mem[a[8:1]];
    endfunction

    function automatic logic [7:0] exp_byte(input logic [AW-1:0] a);
        logic [15:0] w;
        w = mem_rd(a);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic clear_stats();
        got.delete();
        episodes = 0; req_cycles = 0; nxm_cnt = 0; nxm_at = -1; par_cnt = 0;
        valid_cnt = 0; pre_hs_valid = 0; seen_hs = 0;
        prev_hs = 0; prev_valid = 0; inc_pend = 0; req_prev = 0;
    endtask

    // One clock cycle: drive at negedge, settle, then sample and check.
    task automatic step();
        logic [15:0] w;
        bit          hs;
        @(negedge clk);
        if (inc_pend) lpBAR = lpBAR + 1'b1;
        inc_pend = 0;
        dmaACK   = 1'b0;
        dmaDATA  = 16'($urandom);
        dmaPAR   = 2'($urandom);
        if (dmaREQ) begin
            if (!req_prev) begin
                episodes++;
                lat  = $urandom_range(0, 3);
                wcnt = 0;
            end
            if (ack_en && wcnt == lat) dmaACK = 1'b1;
            wcnt++;
            req_cycles++;
        end
        if (force_ack) dmaACK = 1'b1;
        if (dmaACK) begin
            w       = mem_rd(lpBAR);
            dmaDATA = w;
            dmaPAR  = {~^w[15:8], ~^w[7:0]};
            if (bad_lo) dmaPAR[0] = ~dmaPAR[0];
        end
        req_prev = dmaREQ;
        if (hold_left > 0) begin
            byteREADY = 1'b0;
            if (byteVALID) hold_left--;
        end else begin
            byteREADY = rnd_ready ? (($urandom % 4) != 0) : 1'b1;
        end
        lpGO      = go_req || (go_noise && lpBUSY && (($urandom % 8) == 0));
        lpSETDONE = 1'b0;
        #1;
        lpSETDONE = lpINCBCTR && (bc_rem == 1);
        #1;
        if (!rst) begin
            hs = byteVALID && byteREADY;
            check("inc_bctr", lpINCBCTR, hs);
            check("inc_bar", lpINCBAR, hs);
            if (dmaREQ) check("addr", dmaADDR, {lpBAR[AW-1:1], 1'b0});
            if (prev_hs) check("gap", byteVALID, 1'b0);
            if (prev_valid && !prev_hs) begin
                check("hold_valid", byteVALID, 1'b1);
                check("hold_data", byteDATA, prev_data);
            end
            if (byteVALID) begin
                valid_cnt++;
                if (!seen_hs) begin
                    if (hs) seen_hs = 1;
                    else pre_hs_valid++;
                end
            end
            if (hs) begin
                got.push_back(byteDATA);
                inc_pend = 1;
                if (bc_rem > 0) bc_rem--;
            end
            if (lpSETNXM) begin
                nxm_cnt++;
                nxm_at = req_cycles;
            end
            if (lpSETPAR) par_cnt++;
            prev_valid = byteVALID && !lpINIT;
            prev_hs    = hs && !lpINIT;
            prev_data  = byteDATA;
        end
    endtask

    task automatic run_xfer(input logic [AW-1:0] start, input int n);
        int cyc;
        clear_stats();
        lpBAR  = start;
        bc_rem = n;
        go_req = 1;
        step();
        go_req = 0;
        step();
        cyc = 0;
        while (lpBUSY && cyc < 3000) begin
            step();
            cyc++;
        end
        if (cyc >= 3000) check("xfer_finished", 32'd0, 32'd1);
    endtask

    task automatic check_stream(input logic [AW-1:0] start, input int n);
        logic [AW-1:0] a;
        check("nbytes", got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            a = start + AW'(i);
            check("byte", got[i], exp_byte(a));
        end
        check("episodes", episodes, ((int'(start) + n - 1) >> 1) - (int'(start) >> 1) + 1);
        check("no_nxm", nxm_cnt, 0);
        check("no_par", par_cnt, 0);
        check("idle", lpBUSY, 1'b0);
    endtask

    initial begin
        logic [7:0]    e1 [4];
        logic [7:0]    e2 [3];
        logic [AW-1:0] st;
        int            n, k;
        e1 = '{8'h41, 8'h42, 8'h43, 8'h44};
        e2 = '{8'h5A, 8'h01, 8'h02};
        rst = 1; lpINIT = 0; lpGO = 0; lpSETDONE = 0; dmaACK = 0; byteREADY = 0;
        lpBAR = 18'o1001; dmaDATA = 0; dmaPAR = 0;
        ack_en = 1; force_ack = 0; bad_lo = 0; go_noise = 0; go_req = 0; rnd_ready = 0;
        hold_left = 0; bc_rem = 0;
        foreach (mem[i]) mem[i] = 16'($urandom);
        clear_stats();
        repeat (3) step();
        check("rst_req", dmaREQ, 1'b0);
        check("rst_addr", dmaADDR, '0);
        check("rst_data", byteDATA, 8'h00);
        check("rst_valid", byteVALID, 1'b0);
        check("rst_incb", lpINCBCTR, 1'b0);
        check("rst_inca", lpINCBAR, 1'b0);
        check("rst_busy", lpBUSY, 1'b0);
        check("rst_nxm", lpSETNXM, 1'b0);
        check("rst_par", lpSETPAR, 1'b0);
        rst = 0;
        step();

        // Even start, four bytes over two words
        mem[0] = 16'h4241; mem[1] = 16'h4443;
        run_xfer(18'o1000, 4);
        check_stream(18'o1000, 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("t1_byte", got[i], e1[i]);
        check("t1_episodes", episodes, 2);

        // Odd start: high byte only from first word
        mem[0] = 16'h5A55; mem[1] = 16'h0201;
        run_xfer(18'o1001, 3);
        check_stream(18'o1001, 3);
        for (int i = 0; i < 3 && i < got.size(); i++) check("t2_byte", got[i], e2[i]);

        // Back-pressure for 20 valid cycles
        hold_left = 20;
        run_xfer(18'o2000, 2);
        check_stream(18'o2000, 2);
        check("t3_hold_cycles", pre_hs_valid, 20);

        // Bus timeout
        ack_en = 0;
        run_xfer(18'o3000, 2);
        check("t4_req_cycles", req_cycles, TMO);
        check("t4_nxm_cnt", nxm_cnt, 1);
        check("t4_nxm_at", nxm_at, TMO);
        check("t4_no_valid", valid_cnt, 0);
        check("t4_idle", lpBUSY, 1'b0);
        ack_en = 1;

        // lpINIT mid-fetch with a late ack
        clear_stats();
        ack_en = 0; lpBAR = 18'o4000; bc_rem = 1;
        go_req = 1; step(); go_req = 0;
        k = 0;
        while (req_cycles < 2 && k < 10) begin step(); k++; end
        lpINIT = 1; step(); lpINIT = 0;
        force_ack = 1; step(); force_ack = 0;
        check("t5_req", dmaREQ, 1'b0);
        repeat (4) step();
        check("t5_busy", lpBUSY, 1'b0);
        check("t5_valid", valid_cnt, 0);
        check("t5_bytes", got.size(), 0);
        check("t5_nxm", nxm_cnt, 0);
        ack_en = 1;

        // Bad low parity at an even address
        mem[2] = 16'h0041; bad_lo = 1;
        run_xfer(18'o1004, 1);
        bad_lo = 0;
`ifdef LPDMA_PARITY_EN
        check("t6_par", par_cnt, 1);
        check("t6_valid", valid_cnt, 0);
`else
        check("t6_par", par_cnt, 0);
        check("t6_bytes", got.size(), 1);
        if (got.size() > 0) check("t6_byte", got[0], 8'h41);
`endif
        check("t6_idle", lpBUSY, 1'b0);

        // Randomized transfers with back-pressure and stray lpGO
        rnd_ready = 1; go_noise = 1;
        for (int t = 0; t < 12; t++) begin
            foreach (mem[i]) mem[i] = 16'($urandom);
            st = AW'($urandom_range(0, 511));
            n  = $urandom_range(1, 9);
            run_xfer(st, n);
            check_stream(st, n);
        end
        go_noise = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
